sync_fifo_flags: RTL and testbench

Parametrised single-clock synchronous FIFO, the next generation of the team's basic FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy output and sticky overflow/underflow error flags.
- Adds a selectable first-word-fall-through (FWFT) read mode and non-power-of-two depth support.
- Sits between producer/consumer blocks on the same clock as the general-purpose buffer.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_mem.sv | 43 ++++
 rtl/sync_fifo_flags.sv | 117 +++++++++++
 tb/tb_sync_fifo_flags.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO.
//   ptr_w(depth)  : read/write pointer width for a given depth
//   cnt_w(depth)  : occupancy counter width (must represent 0..depth)
//   fifo_status_t : flag bundle for monitors and testbenches
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register-array storage with one synchronous write port
// and one read port. REG_RD=1 gives a registered read (data captured on
// rd_en, reset to zero); REG_RD=0 gives a combinational read of rd_addr.
// Storage itself is never reset.
// Ports:
//   clk, rst          : clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read strobe (registered mode) and address
//   rd_data           : read data
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter bit REG_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (REG_RD) begin : g_reg_rd
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_q <= '0;
      else if (rd_en) rd_q <= mem[rd_addr];
    end
    assign rd_data = rd_q;
  end else begin : g_comb_rd
    assign rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy output, sticky overflow/underflow flags and an optional
// first-word-fall-through read mode. Any DEPTH >= 2 is supported; pointers
// wrap by compare rather than by natural overflow.
// Ports:
//   clk, rst      : clock, async active-high reset
//   wr_en/data_in : write request and data (accepted only when not full)
//   rd_en         : read request / pop (accepted only when not empty)
//   data_out      : FWFT=0 registered read data; FWFT=1 head of queue
//   full, empty, almost_full, almost_empty : decoded from registered count
//   count         : current occupancy
//   overflow, underflow : sticky error flags, cleared by clr_err
//   clr_err       : synchronous clear of the error flags (set wins)
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (WIDTH < 1) begin : g_chk_width
    $fatal(1, "sync_fifo_flags: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "sync_fifo_flags: DEPTH must be >= 2");
  end
  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
    $fatal(1, "sync_fifo_flags: need AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_ok;
  logic          rd_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (cnt == CW'(DEPTH));
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= CW'(AF_THRESH));
  assign almost_empty = (cnt <= CW'(AE_THRESH));
  assign count        = cnt;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      // A single case keeps the count from ever seeing two competing updates.
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .AW     (PW),
    .REG_RD (FWFT == 0)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Three FIFO configurations driven by one shared stimulus stream:
//   inst 0: DEPTH=16 FWFT=0 AF=14 AE=2
//   inst 1: DEPTH=5  FWFT=0 AF=3  AE=2
//   inst 2: DEPTH=8  FWFT=1 AF=6  AE=2
// Each is checked every cycle against a queue model, plus literal checks.
module tb_sync_fifo_flags;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  logic [7:0] d0, d1, d2;
  logic [4:0] c0;
  logic [2:0] c1;
  logic [3:0] c2;
  logic f0, e0, af0, ae0, o0, u0;
  logic f1, e1, af1, ae1, o1, u1;
  logic f2, e2, af2, ae2, o2, u2;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_d16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d0), .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
    .count(c0), .overflow(o0), .underflow(u0), .clr_err(clr_err));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d1), .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
    .count(c1), .overflow(o1), .underflow(u1), .clr_err(clr_err));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d2), .full(f2), .empty(e2), .almost_full(af2), .almost_empty(ae2),
    .count(c2), .overflow(o2), .underflow(u2), .clr_err(clr_err));

  fifo_status_t st0, st1, st2;
  assign st0 = {f0, e0, af0, ae0, o0, u0};
  assign st1 = {f1, e1, af1, ae1, o1, u1};
  assign st2 = {f2, e2, af2, ae2, o2, u2};

  int n_cmp  = 0;
  int n_fail = 0;

  // Queue model: circular buffer described by head index and size.
  int         dep [3] = '{16, 5, 8};
  int         afth[3] = '{14, 3, 6};
  int         aeth[3] = '{2, 2, 2};
  bit         fw  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] mbuf[3][16];
  int         mhd [3];
  int         mn  [3];
  bit         movf[3];
  bit         munf[3];
  logic [7:0] mdout[3];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input int act_cnt, input fifo_status_t act_st,
                          input logic [7:0] act_d);
    fifo_status_t exp_st;
    exp_st = {mn[i] == dep[i], mn[i] == 0, mn[i] >= afth[i], mn[i] <= aeth[i], movf[i], munf[i]};
    n_cmp++;
    if (act_cnt != mn[i] || act_st != exp_st) begin
      n_fail++;
      $display("FAIL model_inst%0d @%0t: count %0d flags %b, expected count %0d flags %b",
               i, $time, act_cnt, act_st, mn[i], exp_st);
    end
    if (!fw[i] || mn[i] > 0) begin
      n_cmp++;
      if (act_d !== (fw[i] ? mbuf[i][mhd[i]] : mdout[i])) begin
        n_fail++;
        $display("FAIL model_data%0d @%0t: got 0x%0h expected 0x%0h", i, $time, act_d,
                 fw[i] ? mbuf[i][mhd[i]] : mdout[i]);
      end
    end
  endtask

  // Compare the state left by the last edge, then predict the next edge
  // from the inputs that are already stable for it.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mhd[i] = 0; mn[i] = 0; movf[i] = 1'b0; munf[i] = 1'b0; mdout[i] = 8'h00;
      end
    end
    cmp_inst(0, int'(c0), st0, d0);
    cmp_inst(1, int'(c1), st1, d1);
    cmp_inst(2, int'(c2), st2, d2);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        bit is_full, is_empty;
        is_full  = (mn[i] == dep[i]);
        is_empty = (mn[i] == 0);
        if (wr_en && is_full)       movf[i] = 1'b1;
        else if (clr_err)           movf[i] = 1'b0;
        if (rd_en && is_empty)      munf[i] = 1'b1;
        else if (clr_err)           munf[i] = 1'b0;
        if (rd_en && !is_empty) begin
          mdout[i] = mbuf[i][mhd[i]];
          mhd[i]   = (mhd[i] + 1) % dep[i];
          mn[i]    = mn[i] - 1;
        end
        if (wr_en && !is_full) begin
          mbuf[i][(mhd[i] + mn[i]) % dep[i]] = data_in;
          mn[i] = mn[i] + 1;
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr_en = w; rd_en = r; data_in = d; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(c0), 0);
    chk("reset_empty", int'(e0), 1);
    chk("reset_ae", int'(ae0), 1);
    chk("reset_af", int'(af0), 0);
    chk("reset_dout", int'(d0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: fill and drain the 16-deep instance
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 13) chk("af_at_13", int'(af0), 0);
      if (i == 14) chk("af_at_14", int'(af0), 1);
      if (i == 15) chk("full_at_15", int'(f0), 0);
    end
    chk("full_at_16", int'(f0), 1);
    chk("count_16", int'(c0), 16);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("read_order", int'(d0), i);
      if (i == 13) chk("ae_at_3", int'(ae0), 0);
      if (i == 14) chk("ae_at_2", int'(ae0), 1);
    end
    chk("empty_after_drain", int'(e0), 1);

    // 2: simultaneous access while full, overflow set-wins and clear
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("ovf_set_wins", int'(o0), 1);
    chk("count_stays_16", int'(c0), 16);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("full_rw_count", int'(c0), 15);
    chk("full_rw_ovf", int'(o0), 1);
    chk("full_rw_head", int'(d0), 8'h20);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", int'(o0), 0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("last_of_burst", int'(d0), 8'h2F);
    chk("empty_again", int'(e0), 1);

    // 3: simultaneous access while empty
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("empty_rw_count", int'(c0), 1);
    chk("empty_rw_unf", int'(u0), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("empty_rw_data", int'(d0), 8'hA5);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // 4: streaming through the 5-deep instance, pointers wrap
    cyc(1'b1, 1'b0, 8'h40, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h41 + k), 1'b0);
      chk("d5_count_1", int'(c1), 1);
      chk("d5_order", int'(d1), 8'h40 + k);
    end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("d5_tail", int'(d1), 8'h54);
    chk("d5_empty", int'(e1), 1);

    // 5: first-word-fall-through
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("fwft_not_empty", int'(e2), 0);
    chk("fwft_data", int'(d2), 8'h3C);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fwft_hold", int'(d2), 8'h3C);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_popped", int'(e2), 1);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    chk("pre_rst_count", int'(c0), 7);
    chk("pre_rst_d5_ovf", int'(o1), 1);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_count", int'(c0), 0);
    chk("async_empty", int'(e0), 1);
    chk("async_ae", int'(ae0), 1);
    chk("async_d5_ovf", int'(o1), 0);
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    chk("post_rst_fwft", int'(d2), 8'h77);
    cyc(1'b1, 1'b0, 8'h78, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_read", int'(d0), 8'h77);
    chk("post_rst_count", int'(c0), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
